// File: rtl/ddsm_frac_decoder.sv
// Receive-side window integrator for the 4-bit signed modulator stream.
// Reports the window sum plus the min/max sample of each completed window.
module ddsm_frac_decoder #(
   parameter int P_WIN_LOG2 = 4,
   parameter int P_SUM_W    = P_WIN_LOG2 + 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [3:0]         i_frac,
   input  logic               i_en,
   input  logic               i_start,
   input  logic               i_abort,
   input  logic               i_cont,
   output logic [P_SUM_W-1:0] o_sum,
   output logic [3:0]         o_min,
   output logic [3:0]         o_max,
   output logic               o_valid,
   output logic               o_busy
);

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      DONE
   } state_t;

   localparam logic signed [3:0] MIN_INIT = 4'sb0111;
   localparam logic signed [3:0] MAX_INIT = 4'sb1000;

   state_t                     state;
   logic signed [P_SUM_W-1:0]  acc;
   logic signed [P_SUM_W-1:0]  samp;
   logic signed [P_SUM_W-1:0]  sum_nxt;
   logic [P_WIN_LOG2-1:0]      cnt;
   logic signed [3:0]          frac_s;
   logic signed [3:0]          rmin;
   logic signed [3:0]          rmax;
   logic signed [3:0]          min_nxt;
   logic signed [3:0]          max_nxt;
   logic                       last;

   always_comb begin
      frac_s  = signed'(i_frac);
      samp    = {{(P_SUM_W-4){i_frac[3]}}, i_frac};
      sum_nxt = acc + samp;
      min_nxt = (frac_s < rmin) ? frac_s : rmin;
      max_nxt = (frac_s > rmax) ? frac_s : rmax;
      last    = &cnt;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= IDLE;
         acc     <= '0;
         cnt     <= '0;
         rmin    <= '0;
         rmax    <= '0;
         o_sum   <= '0;
         o_min   <= '0;
         o_max   <= '0;
         o_valid <= 1'b0;
         o_busy  <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (i_start && !i_abort) begin
                  state  <= ACC;
                  o_busy <= 1'b1;
                  acc    <= '0;
                  cnt    <= '0;
                  rmin   <= MIN_INIT;
                  rmax   <= MAX_INIT;
               end
            end
            ACC: begin
               if (i_abort) begin
                  state  <= IDLE;
                  o_busy <= 1'b0;
               end else if (i_en) begin
                  if (last) begin
                     o_sum   <= sum_nxt;
                     o_min   <= min_nxt;
                     o_max   <= max_nxt;
                     o_valid <= 1'b1;
                     // Re-arm in the same edge so continuous mode is gapless
                     acc     <= '0;
                     cnt     <= '0;
                     rmin    <= MIN_INIT;
                     rmax    <= MAX_INIT;
                     if (!i_cont) begin
                        state  <= DONE;
                        o_busy <= 1'b0;
                     end
                  end else begin
                     acc  <= sum_nxt;
                     cnt  <= cnt + 1'b1;
                     rmin <= min_nxt;
                     rmax <= max_nxt;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ddsm_frac_decoder.sv
// Bench for ddsm_frac_decoder: directed windows with a scoreboard of
// expected sum/min/max checked whenever o_valid pulses.
module tb_ddsm_frac_decoder;

   typedef struct {
      int sum;
      int mn;
      int mx;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [3:0] frac;
   logic       en;
   logic       start;
   logic       abort;
   logic       cont;
   logic [7:0] o_sum;
   logic [3:0] o_min;
   logic [3:0] o_max;
   logic       o_valid;
   logic       o_busy;

   int   total;
   int   bad;
   int   vcount;
   int   cyc;
   int   t_ent;
   int   v0;
   exp_t sb[$];
   int   vtimes[$];

   ddsm_frac_decoder #(.P_WIN_LOG2(4), .P_SUM_W(8)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_frac  (frac),
      .i_en    (en),
      .i_start (start),
      .i_abort (abort),
      .i_cont  (cont),
      .o_sum   (o_sum),
      .o_min   (o_min),
      .o_max   (o_max),
      .o_valid (o_valid),
      .o_busy  (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp(input int f, input bit e);
      frac = f[3:0];
      en   = e;
      step();
   endtask

   task automatic push(input int s, input int mn, input int mx);
      exp_t x;
      x.sum = s;
      x.mn  = mn;
      x.mx  = mx;
      sb.push_back(x);
   endtask

   task automatic begin_win();
      start = 1'b1;
      en    = 1'b1;
      step();
      start = 1'b0;
      t_ent = cyc;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      vcount = 0;
      cyc   = 0;
      rst   = 1'b1;
      frac  = '0;
      en    = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      cont  = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (o_valid) begin
               vcount++;
               vtimes.push_back(cyc);
               if (sb.size() == 0) begin
                  chk("unexpected_valid", 1, 0);
               end else begin
                  exp_t x;
                  x = sb.pop_front();
                  chk("sum", int'($signed(o_sum)), x.sum);
                  chk("min", int'($signed(o_min)), x.mn);
                  chk("max", int'($signed(o_max)), x.mx);
               end
            end
         end
      join_none

      step();
      step();
      chk("rst_sum", int'(o_sum), 0);
      chk("rst_min", int'(o_min), 0);
      chk("rst_max", int'(o_max), 0);
      chk("rst_valid", int'(o_valid), 0);
      chk("rst_busy", int'(o_busy), 0);
      rst = 1'b0;
      step();

      // constant +3, single shot
      push(48, 3, 3);
      vtimes.delete();
      begin_win();
      chk("busy_acc", int'(o_busy), 1);
      for (int i = 0; i < 16; i++) smp(3, 1);
      smp(0, 0);
      chk("t1_busy_after", int'(o_busy), 0);
      chk("t1_vcount", vcount, 1);
      chk("t1_latency", (vtimes.size() > 0) ? vtimes[0] - t_ent : -1, 16);

      // extremes
      push(-128, -8, -8);
      begin_win();
      for (int i = 0; i < 16; i++) smp(-8, 1);
      smp(0, 0);
      push(112, 7, 7);
      begin_win();
      for (int i = 0; i < 16; i++) smp(7, 1);
      smp(0, 0);
      chk("t2_vcount", vcount, 3);

      // enable toggling; disabled cycles carry junk samples
      push(24, 1, 2);
      begin_win();
      for (int i = 0; i < 32; i++) begin
         if (i % 2 == 0) smp(((i / 2) % 2 == 0) ? 1 : 2, 1);
         else smp(-7, 0);
         if (i == 30) chk("t3_no_early", vcount, 3);
      end
      smp(0, 0);
      chk("t3_vcount", vcount, 4);

      // continuous ramp, three gapless windows
      for (int w = 0; w < 3; w++) push(-8, -8, 7);
      vtimes.delete();
      cont = 1'b1;
      begin_win();
      for (int i = 0; i < 48; i++) begin
         if (i == 32) cont = 1'b0;
         smp(-8 + (i % 16), 1);
      end
      smp(0, 0);
      chk("t4_vcount", vcount, 7);
      chk("t4_gap0", (vtimes.size() > 1) ? vtimes[1] - vtimes[0] : -1, 16);
      chk("t4_gap1", (vtimes.size() > 2) ? vtimes[2] - vtimes[1] : -1, 16);
      chk("t4_busy_after", int'(o_busy), 0);

      // abort mid-window
      push(48, 3, 3);
      begin_win();
      for (int i = 0; i < 16; i++) smp(3, 1);
      smp(0, 0);
      begin_win();
      for (int i = 0; i < 7; i++) smp(-1, 1);
      abort = 1'b1;
      smp(-1, 1);
      abort = 1'b0;
      smp(-1, 1);
      chk("t5_abort_busy", int'(o_busy), 0);
      chk("t5_hold_sum", int'($signed(o_sum)), 48);
      chk("t5_hold_min", int'($signed(o_min)), 3);
      chk("t5_hold_max", int'($signed(o_max)), 3);
      for (int i = 0; i < 20; i++) smp(-1, 1);
      chk("t5_abort_vcount", vcount, 8);

      // reset mid-window
      begin_win();
      for (int i = 0; i < 7; i++) smp(-1, 1);
      rst = 1'b1;
      smp(-1, 1);
      rst = 1'b0;
      chk("t5_rst_sum", int'(o_sum), 0);
      chk("t5_rst_min", int'(o_min), 0);
      chk("t5_rst_max", int'(o_max), 0);
      chk("t5_rst_busy", int'(o_busy), 0);
      for (int i = 0; i < 20; i++) smp(-1, 1);
      chk("t5_rst_vcount", vcount, 8);

      // abort coinciding with window end
      begin_win();
      for (int i = 0; i < 15; i++) smp(2, 1);
      abort = 1'b1;
      smp(2, 1);
      abort = 1'b0;
      smp(0, 0);
      chk("t5_end_abort_sum", int'(o_sum), 0);
      chk("t5_end_abort_busy", int'(o_busy), 0);
      chk("t5_end_abort_vcount", vcount, 8);

      // start with abort in IDLE is ignored
      start = 1'b1;
      abort = 1'b1;
      smp(1, 1);
      start = 1'b0;
      abort = 1'b0;
      chk("t6_start_abort_busy", int'(o_busy), 0);

      // start pulses inside ACC do not restart the window
      push(13, -2, 1);
      vtimes.delete();
      begin_win();
      for (int i = 0; i < 16; i++) begin
         start = (i == 3 || i == 9);
         smp((i == 5) ? -2 : 1, 1);
      end
      start = 1'b0;
      smp(0, 0);
      chk("t6_vcount", vcount, 9);
      chk("t6_latency", (vtimes.size() > 0) ? vtimes[0] - t_ent : -1, 16);

      v0 = 0;
      while (sb.size() != 0 && v0 < 50) begin
         step();
         v0++;
      end
      chk("sb_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
